mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single 32-bit AXI4-lite master port between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Sits between the riscv core's fetch/load-store logic and the external memory slave.
- Sequences one transaction at a time through the AXI channels and drives the correct protection bits.
- Round-robin arbitration when both requesters are pending; returns a one-cycle response pulse to the winner.

Parameters:
- INST_PROT, 3'b101, arprot for instruction fetches
- DATA_PROT, 3'b000, arprot/awprot for data accesses

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- i_req_valid  in  1  fetch request pending
- i_req_addr  in  32  fetch address
- i_req_ready  out  1  fetch request accepted (1-cycle pulse)
- i_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- i_rsp_data  out  32  fetched instruction
- i_rsp_err  out  1  fetch failed (qualified by i_rsp_valid)
- d_req_valid  in  1  data request pending
- d_req_write  in  1  1 = store, 0 = load
- d_req_addr  in  32  data address
- d_req_wdata  in  32  store data
- d_req_wstrb  in  4  store byte strobes
- d_req_ready  out  1  data request accepted (1-cycle pulse)
- d_rsp_valid  out  1  data response (1-cycle pulse)
- d_rsp_rdata  out  32  load data
- d_rsp_err  out  1  data access failed (qualified by d_rsp_valid)
- awvalid/awready/awaddr[32]/awprot[3]  out/in/out/out  AXI write address channel
- wvalid/wready/wdata[32]/wstrb[4]  out/in/out/out  AXI write data channel
- bvalid/bready/bresp[2]  in/out/in  AXI write response channel
- arvalid/arready/araddr[32]/arprot[3]  out/in/out/out  AXI read address channel
- rvalid/rready/rdata[32]/rresp[2]  in/out/in/in  AXI read data channel

Behaviour:
- Reset (reset low, async):
  - state = IDLE; last_grant = data, so instruction fetch wins first contention.
  - All valid, ready and rsp outputs = 0; all address, data, prot and strobe outputs = 0.
- Reset asserted mid-transaction aborts immediately, with no response pulse; the slave shares the same reset.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
- IDLE arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the one not equal to last_grant, then update last_grant.
- Grant cycle:
  - Pulse the winner's *_req_ready for one cycle.
  - Latch address, write flag, wdata, wstrb and source into internal registers; requesters may change their inputs afterwards.
- Read grant:
  - Next cycle arvalid = 1, araddr = latched address, arprot = INST_PROT or DATA_PROT by source; rready = 1. State RD_ADDR.
- RD_ADDR:
  - On arvalid && arready, drop arvalid and go to RD_DATA.
  - If rvalid && rready arrives in the same cycle, complete the read directly (skip RD_DATA).
- RD_DATA:
  - On rvalid && rready, drop rready and capture rdata.
  - Next cycle pulse the source's rsp_valid with the data; err = (rresp != 2'b00 && rresp != 2'b01).
  - Return to IDLE.
- Write grant (data only):
  - awvalid = wvalid = 1, awprot = DATA_PROT. State WR_ADDR_DATA.
  - Each valid drops independently on its own handshake; the two may complete in either order or the same cycle.
  - When both are done, assert bready and go to WR_RESP.
- WR_RESP:
  - On bvalid && bready, drop bready.
  - Next cycle pulse d_rsp_valid; err = (bresp != 2'b00); d_rsp_rdata = 0.
  - Return to IDLE.
- Latency with a zero-wait slave:
  - Read: request accepted at cycle 0, arvalid at cycle 1, rsp_valid at cycle 3.
  - Write: rsp_valid at cycle 4.
- Outstanding transactions: at most one; no new grant until the response pulse cycle. Arbitration resumes in the cycle after the pulse.
- Valids are held until handshake (AXI rule); addresses, data and strobes are stable while valid.
- rsp outputs are 0 whenever rsp_valid = 0. Requesters must accept rsp pulses; there is no backpressure.
- A fetch request with d_req_write is not possible: instruction fetch is always a read.

Decomposition:
- Shared package: state encoding localparams, INST_PROT/DATA_PROT defaults, rresp/bresp codes (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11), source ids (SRC_INST, SRC_DATA).
- Natural sub-module: rr_arbiter2, a two-input round-robin grant with last_grant register.

Test Plan:
- Fetch only, i_req_addr=32'h0000_0010, slave returns rdata=32'h0000_0013, rresp=00 -> araddr=32'h10, arprot=101, i_rsp_valid at cycle 3, i_rsp_data=32'h13, i_rsp_err=0.
- Store d_req_addr=32'h100, wdata=32'hDEAD_BEEF, wstrb=4'b1111; slave gives wready 2 cycles before awready -> awaddr=32'h100, awprot=000, wdata held until its handshake, single d_rsp_valid with err=0.
- Both requesters valid continuously from reset -> grant order inst, data, inst, data; no requester granted twice in a row.
- Load returns rresp=2'b10 -> d_rsp_valid with d_rsp_err=1; next request proceeds normally.
- Store returns bresp=2'b11 -> d_rsp_err=1.
- Reset driven low while in RD_DATA with rvalid pending -> arvalid, rready and all rsp outputs 0 in the same cycle (async); state IDLE; no response pulse after release.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4-lite master arbiter:
// FSM states, requester ids, AXI response codes and default protection bits.
package mem_bus_arbiter_pkg;

  localparam logic [2:0] INST_PROT_DEFAULT = 3'b101;
  localparam logic [2:0] DATA_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP
  } state_t;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant (instruction fetch vs data).
// Ports: clk, reset (async active-low), en (arbitration allowed this cycle),
//        req_inst/req_data (pending requests), grant_inst/grant_data (one-hot or zero).
// last_grant resets to data so the fetch side wins the first contention.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_inst,
  input  logic req_data,
  output logic grant_inst,
  output logic grant_data
);

  src_t last_grant;

  always_comb begin
    grant_inst = en && req_inst && (!req_data || (last_grant == SRC_DATA));
    grant_data = en && req_data && (!req_inst || (last_grant == SRC_INST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= SRC_DATA;
    end else if (grant_inst) begin
      last_grant <= SRC_INST;
    end else if (grant_data) begin
      last_grant <= SRC_DATA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one AXI4-lite master port between instruction fetch (read-only) and
// data load/store. One transaction outstanding at a time; round-robin on contention.
// Ports:
//   clk, reset (async active-low)
//   i_req_*/i_rsp_* : fetch request (valid/addr, ready pulse) and response pulse
//   d_req_*/d_rsp_* : data request (valid/write/addr/wdata/wstrb, ready pulse) and response pulse
//   aw*/w*/b*/ar*/r* : AXI4-lite master channels
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [2:0] INST_PROT = INST_PROT_DEFAULT,
  parameter logic [2:0] DATA_PROT = DATA_PROT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  input  logic        d_req_write,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  state_t      state, state_n;
  src_t        src, src_n;
  logic        run;
  logic        arb_en, grant_inst, grant_data, rd_done;
  logic        arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  logic [31:0] araddr_n, awaddr_n, wdata_n;
  logic [2:0]  arprot_n, awprot_n;
  logic [3:0]  wstrb_n;
  logic        i_rsp_valid_n, i_rsp_err_n, d_rsp_valid_n, d_rsp_err_n;
  logic [31:0] i_rsp_data_n, d_rsp_rdata_n;

  // Ready is combinational from the grant; 'run' keeps it low while reset is held.
  // No new grant during the response pulse cycle.
  assign arb_en = run && (state == IDLE) && !i_rsp_valid && !d_rsp_valid;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .en         (arb_en),
    .req_inst   (i_req_valid),
    .req_data   (d_req_valid),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  assign i_req_ready = grant_inst;
  assign d_req_ready = grant_data;

  always_comb begin
    state_n       = state;
    src_n         = src;
    arvalid_n     = arvalid;
    araddr_n      = araddr;
    arprot_n      = arprot;
    rready_n      = rready;
    awvalid_n     = awvalid;
    awaddr_n      = awaddr;
    awprot_n      = awprot;
    wvalid_n      = wvalid;
    wdata_n       = wdata;
    wstrb_n       = wstrb;
    bready_n      = bready;
    i_rsp_valid_n = 1'b0;
    i_rsp_data_n  = '0;
    i_rsp_err_n   = 1'b0;
    d_rsp_valid_n = 1'b0;
    d_rsp_rdata_n = '0;
    d_rsp_err_n   = 1'b0;
    rd_done       = 1'b0;

    case (state)
      IDLE: begin
        if (grant_inst) begin
          src_n     = SRC_INST;
          araddr_n  = i_req_addr;
          arprot_n  = INST_PROT;
          arvalid_n = 1'b1;
          rready_n  = 1'b1;
          state_n   = RD_ADDR;
        end else if (grant_data) begin
          src_n = SRC_DATA;
          if (d_req_write) begin
            awaddr_n  = d_req_addr;
            awprot_n  = DATA_PROT;
            wdata_n   = d_req_wdata;
            wstrb_n   = d_req_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_ADDR_DATA;
          end else begin
            araddr_n  = d_req_addr;
            arprot_n  = DATA_PROT;
            arvalid_n = 1'b1;
            rready_n  = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (arvalid && arready) begin
          arvalid_n = 1'b0;
          if (rvalid && rready) rd_done = 1'b1;
          else                  state_n = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid && rready) rd_done = 1'b1;
      end
      WR_ADDR_DATA: begin
        if (awvalid && awready) awvalid_n = 1'b0;
        if (wvalid && wready)   wvalid_n  = 1'b0;
        // Both channels done once both registered valids have dropped.
        if (!awvalid && !wvalid) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid && bready) begin
          bready_n      = 1'b0;
          d_rsp_valid_n = 1'b1;
          d_rsp_err_n   = (bresp != RESP_OKAY);
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (rd_done) begin
      rready_n = 1'b0;
      state_n  = IDLE;
      if (src == SRC_INST) begin
        i_rsp_valid_n = 1'b1;
        i_rsp_data_n  = rdata;
        i_rsp_err_n   = !((rresp == RESP_OKAY) || (rresp == RESP_EXOKAY));
      end else begin
        d_rsp_valid_n = 1'b1;
        d_rsp_rdata_n = rdata;
        d_rsp_err_n   = !((rresp == RESP_OKAY) || (rresp == RESP_EXOKAY));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      src         <= SRC_DATA;
      run         <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      arprot      <= '0;
      rready      <= 1'b0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      awprot      <= '0;
      wvalid      <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      bready      <= 1'b0;
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      i_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= '0;
      d_rsp_err   <= 1'b0;
    end else begin
      state       <= state_n;
      src         <= src_n;
      run         <= 1'b1;
      arvalid     <= arvalid_n;
      araddr      <= araddr_n;
      arprot      <= arprot_n;
      rready      <= rready_n;
      awvalid     <= awvalid_n;
      awaddr      <= awaddr_n;
      awprot      <= awprot_n;
      wvalid      <= wvalid_n;
      wdata       <= wdata_n;
      wstrb       <= wstrb_n;
      bready      <= bready_n;
      i_rsp_valid <= i_rsp_valid_n;
      i_rsp_data  <= i_rsp_data_n;
      i_rsp_err   <= i_rsp_err_n;
      d_rsp_valid <= d_rsp_valid_n;
      d_rsp_rdata <= d_rsp_rdata_n;
      d_rsp_err   <= d_rsp_err_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a configurable-latency AXI4-lite slave.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        d_req_valid = 1'b0;
  logic        d_req_write = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic [3:0]  d_req_wstrb = '0;
  logic        d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [31:0] rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.INST_PROT(3'b101), .DATA_PROT(3'b000)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave configuration (set by the stimulus process before each transaction)
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

  // Slave: drives at the falling edge; pend_* are handshakes that the next rising edge completes.
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt;
    bit r_wait, aw_got, w_got, pend_ar, pend_r, pend_aw, pend_w, pend_b;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
    r_wait = 0; aw_got = 0; w_got = 0;
    pend_ar = 0; pend_r = 0; pend_aw = 0; pend_w = 0; pend_b = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        r_wait = 0; aw_got = 0; w_got = 0;
        pend_ar = 0; pend_r = 0; pend_aw = 0; pend_w = 0; pend_b = 0;
      end else begin
        if (pend_ar) begin r_wait = 1; r_cnt = 0; end
        if (pend_r) begin rvalid = 0; rdata = '0; rresp = '0; end
        if (pend_aw) aw_got = 1;
        if (pend_w) w_got = 1;
        if (pend_b) begin bvalid = 0; bresp = '0; end
        arready = arvalid && (ar_cnt >= ar_lat);
        ar_cnt  = (arvalid && !arready) ? ar_cnt + 1 : 0;
        awready = awvalid && (aw_cnt >= aw_lat);
        aw_cnt  = (awvalid && !awready) ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_lat);
        w_cnt   = (wvalid && !wready) ? w_cnt + 1 : 0;
        if (r_wait) begin
          if (r_cnt >= r_lat) begin
            rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_wait = 0;
          end else r_cnt++;
        end
        if (aw_got && w_got) begin
          bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0;
        end
        pend_ar = arvalid && arready;
        pend_r  = rvalid && rready;
        pend_aw = awvalid && awready;
        pend_w  = wvalid && wready;
        pend_b  = bvalid && bready;
      end
    end
  end

  // One request through to its response; lat counts cycles from the accept cycle.
  task automatic run_txn(input bit inst, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb,
                         output int lat, output logic [31:0] data, output logic err,
                         output logic [31:0] seen_addr, output logic [2:0] seen_prot,
                         output logic extra, output logic hold_bad);
    bit acc, done, seen;
    lat = -1; data = '0; err = 0; seen_addr = '0; seen_prot = '0; extra = 0; hold_bad = 0;
    acc = 0; done = 0; seen = 0;
    @(negedge clk);
    if (inst) begin
      i_req_valid = 1; i_req_addr = addr;
    end else begin
      d_req_valid = 1; d_req_write = wr; d_req_addr = addr; d_req_wdata = wd; d_req_wstrb = strb;
    end
    for (int n = 0; n < 20 && !acc; n++) begin
      #1;
      acc = inst ? i_req_ready : d_req_ready;
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      i_req_valid = 0; d_req_valid = 0;
      return;
    end
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Requester changes its inputs right after acceptance.
        i_req_valid = 0; d_req_valid = 0;
        i_req_addr = ~addr; d_req_addr = ~addr; d_req_wdata = ~wd; d_req_wstrb = ~strb;
        d_req_write = 0;
      end
      #1;
      if (!seen && (arvalid || awvalid)) begin
        seen = 1;
        seen_addr = arvalid ? araddr : awaddr;
        seen_prot = arvalid ? arprot : awprot;
      end
      if (wvalid && ((wdata !== wd) || (wstrb !== strb))) hold_bad = 1;
      if (awvalid && (awaddr !== addr)) hold_bad = 1;
      if (arvalid && (araddr !== addr)) hold_bad = 1;
      if (inst ? i_rsp_valid : d_rsp_valid) begin
        done = 1;
        data = inst ? i_rsp_data : d_rsp_rdata;
        err  = inst ? i_rsp_err : d_rsp_err;
        extra = inst ? d_rsp_valid : i_rsp_valid;
      end
    end
    if (!done) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      lat = -1;
    end else begin
      @(negedge clk);
      #1;
      extra = extra | i_rsp_valid | d_rsp_valid | i_rsp_err | d_rsp_err
                    | (|i_rsp_data) | (|d_rsp_rdata);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    logic [31:0] data, saddr;
    logic [2:0] sprot;
    logic err, extra, hold_bad;
    int gcount, pulses;
    int order[4];
    bit both, arv_seen;

    // Reset state, with both requests raised to confirm ready stays low in reset.
    i_req_valid = 1; d_req_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {arvalid, awvalid, wvalid, rready, bready, i_req_ready, d_req_ready,
                     i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_strb_prot", {wstrb, arprot, awprot}, 32'd0);
    chk("rst_rsp_data", i_rsp_data | d_rsp_rdata, 32'd0);
    i_req_valid = 0; d_req_valid = 0;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);

    // Fetch, zero-wait slave
    cfg_rdata = 32'h0000_0013; cfg_rresp = 2'b00;
    run_txn(1, 0, 32'h0000_0010, 32'd0, 4'd0, lat, data, err, saddr, sprot, extra, hold_bad);
    chk("f_araddr", saddr, 32'h10);
    chk("f_arprot", {29'd0, sprot}, 32'd5);
    chk("f_latency", lat, 32'd3);
    chk("f_data", data, 32'h13);
    chk("f_err", {31'd0, err}, 32'd0);
    chk("f_single_pulse", {31'd0, extra}, 32'd0);
    chk("f_addr_hold", {31'd0, hold_bad}, 32'd0);

    // Store, wready two cycles ahead of awready
    aw_lat = 2; w_lat = 0; cfg_bresp = 2'b00;
    run_txn(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, lat, data, err, saddr, sprot, extra, hold_bad);
    chk("s_awaddr", saddr, 32'h100);
    chk("s_awprot", {29'd0, sprot}, 32'd0);
    chk("s_hold", {31'd0, hold_bad}, 32'd0);
    chk("s_latency", lat, 32'd6);
    chk("s_err", {31'd0, err}, 32'd0);
    chk("s_rdata_zero", data, 32'd0);
    chk("s_single_pulse", {31'd0, extra}, 32'd0);
    aw_lat = 0;

    // Load with SLVERR, then a fetch with EXOKAY
    cfg_rdata = 32'hCAFE_0001; cfg_rresp = 2'b10;
    run_txn(0, 0, 32'h0000_0200, 32'd0, 4'd0, lat, data, err, saddr, sprot, extra, hold_bad);
    chk("le_err", {31'd0, err}, 32'd1);
    chk("le_data", data, 32'hCAFE_0001);
    chk("le_arprot", {29'd0, sprot}, 32'd0);
    chk("le_latency", lat, 32'd3);
    cfg_rdata = 32'h0010_0073; cfg_rresp = 2'b01;
    run_txn(1, 0, 32'h0000_0014, 32'd0, 4'd0, lat, data, err, saddr, sprot, extra, hold_bad);
    chk("fx_err", {31'd0, err}, 32'd0);
    chk("fx_data", data, 32'h0010_0073);
    chk("fx_latency", lat, 32'd3);

    // Store with DECERR, zero-wait; then a store with EXOKAY (also an error for writes)
    cfg_bresp = 2'b11;
    run_txn(0, 1, 32'h0000_0104, 32'h1234_5678, 4'b0011, lat, data, err, saddr, sprot, extra, hold_bad);
    chk("sd_err", {31'd0, err}, 32'd1);
    chk("sd_latency", lat, 32'd4);
    chk("sd_rdata_zero", data, 32'd0);
    chk("sd_hold", {31'd0, hold_bad}, 32'd0);
    cfg_bresp = 2'b01;
    run_txn(0, 1, 32'h0000_0108, 32'h0000_00FF, 4'b0001, lat, data, err, saddr, sprot, extra, hold_bad);
    chk("sx_err", {31'd0, err}, 32'd1);

    // Both requesters valid continuously from reset
    cfg_rresp = 2'b00; cfg_rdata = 32'h0000_0001;
    @(negedge clk);
    reset = 0;
    i_req_valid = 1; i_req_addr = 32'h40;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h80;
    repeat (2) @(negedge clk);
    reset = 1;
    gcount = 0; both = 0;
    for (int n = 0; n < 200 && gcount < 4; n++) begin
      @(negedge clk);
      #1;
      if (i_req_ready && d_req_ready) both = 1;
      if (i_req_ready) begin order[gcount] = 0; gcount++; end
      else if (d_req_ready) begin order[gcount] = 1; gcount++; end
    end
    @(negedge clk);
    i_req_valid = 0; d_req_valid = 0;
    repeat (10) @(negedge clk);
    chk("rr_count", gcount, 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), order[k], k % 2);
    chk("rr_both", {31'd0, both}, 32'd0);

    // Reset asserted during RD_DATA
    r_lat = 6;
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 32'h300;
    #1;
    chk("ra_accept", {31'd0, i_req_ready}, 32'd1);
    @(negedge clk);
    i_req_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("ra_rd_data_phase", {30'd0, arvalid, rready}, 32'd1);
    i_req_valid = 1;
    reset = 0;
    #1;
    chk("ra_ctrl", {arvalid, rready, i_rsp_valid, d_rsp_valid, i_req_ready, i_rsp_err}, 32'd0);
    chk("ra_araddr", araddr, 32'd0);
    chk("ra_rsp_data", i_rsp_data, 32'd0);
    i_req_valid = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    pulses = 0; arv_seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      #1;
      if (i_rsp_valid || d_rsp_valid) pulses++;
      if (arvalid) arv_seen = 1;
    end
    chk("ra_no_pulse", pulses, 32'd0);
    chk("ra_no_arvalid", {31'd0, arv_seen}, 32'd0);
    r_lat = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
